// File: rtl/yutorina_bus_timer_pkg.sv
// Shared encodings for the bus timer: handshake states, register map and
// control/status bit positions.
package yutorina_bus_timer_pkg;

    // Handshake states of the bus responder
    typedef enum logic [1:0] {
        BUS_SLAVE_IDLE  = 2'd0,
        BUS_SLAVE_WAIT  = 2'd1,
        BUS_SLAVE_READY = 2'd2
    } bus_slave_state_e;

    // Bus direction encoding on rw
    localparam logic BUS_READ  = 1'b1;
    localparam logic BUS_WRITE = 1'b0;

    // Register index (addr[1:0])
    localparam logic [1:0] TIMER_ADDR_CTRL    = 2'd0;
    localparam logic [1:0] TIMER_ADDR_INTR    = 2'd1;
    localparam logic [1:0] TIMER_ADDR_EXPR    = 2'd2;
    localparam logic [1:0] TIMER_ADDR_COUNTER = 2'd3;

    // Bit positions inside CTRL and INTR
    localparam int TIMER_START_LOC    = 0;
    localparam int TIMER_PERIODIC_LOC = 1;
    localparam int TIMER_IRQ_LOC      = 0;

    // Wait counter width, enough for WAIT_CYCLES up to 15
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/yutorina_bus_timer_bus_slave_if.sv
// Bus handshake for the timer: accepts one request at a time, holds it for
// the programmable wait, then presents a single ready cycle. A write is
// flagged as committing during that ready cycle so the register bank updates
// at the edge that ends it.
module yutorina_bus_slave_if
    import yutorina_bus_timer_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       w_data,
    output logic              req_rw,
    output logic [1:0]        req_idx,
    output logic [31:0]       req_wdata,
    output logic              ready,
    output logic              commit
);

    // First count value loaded on entry to WAIT; WAIT exits when it reaches 0
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;

    bus_slave_state_e        state_q, state_d;
    logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                    req_rw_q, req_rw_d;
    logic [1:0]              req_idx_q, req_idx_d;
    logic [31:0]             req_wdata_q, req_wdata_d;

    // Only the low two address bits select a register
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_W-1:2];

    // State, wait counter and latched request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BUS_SLAVE_IDLE;
            wait_cnt_q  <= '0;
            req_rw_q    <= BUS_READ;
            req_idx_q   <= '0;
            req_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            req_rw_q    <= req_rw_d;
            req_idx_q   <= req_idx_d;
            req_wdata_q <= req_wdata_d;
        end
    end

    // Next-state logic; the request is captured only when accepted in IDLE
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        req_rw_d    = req_rw_q;
        req_idx_d   = req_idx_q;
        req_wdata_d = req_wdata_q;
        case (state_q)
            BUS_SLAVE_IDLE: begin
                if (!cs_ && !as_) begin
                    req_rw_d    = rw;
                    req_idx_d   = addr[1:0];
                    req_wdata_d = w_data;
                    if (WAIT_CYCLES > 0) begin
                        state_d    = BUS_SLAVE_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = BUS_SLAVE_READY;
                    end
                end
            end
            BUS_SLAVE_WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = BUS_SLAVE_READY;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            BUS_SLAVE_READY: begin
                state_d = BUS_SLAVE_IDLE;
            end
            default: begin
                state_d = BUS_SLAVE_IDLE;
            end
        endcase
    end

    assign ready     = (state_q == BUS_SLAVE_READY);
    assign commit    = ready && (req_rw_q == BUS_WRITE);
    assign req_rw    = req_rw_q;
    assign req_idx   = req_idx_q;
    assign req_wdata = req_wdata_q;

endmodule

// File: rtl/yutorina_bus_timer.sv
// 32-bit interval timer on the CPU system bus. Four word registers
// (CTRL, INTR, EXPR, COUNTER) behind a wait-state bus responder; raises a
// level interrupt when COUNTER reaches EXPR.
module yutorina_bus_timer
    import yutorina_bus_timer_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 30
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       w_data,
    output logic [31:0]       r_data,
    output logic              rdy_,
    output logic              irq
);

    logic        req_rw;
    logic [1:0]  req_idx;
    logic [31:0] req_wdata;
    logic        ready;
    logic        commit;

    logic        start_q, start_d;
    logic        periodic_q, periodic_d;
    logic        irq_q, irq_d;
    logic [31:0] expr_q, expr_d;
    logic [31:0] counter_q, counter_d;
    logic [31:0] reg_rd;

    yutorina_bus_slave_if #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .ADDR_W      (ADDR_W)
    ) u_bus_slave_if (
        .clk       (clk),
        .rst       (rst),
        .cs_       (cs_),
        .as_       (as_),
        .rw        (rw),
        .addr      (addr),
        .w_data    (w_data),
        .req_rw    (req_rw),
        .req_idx   (req_idx),
        .req_wdata (req_wdata),
        .ready     (ready),
        .commit    (commit)
    );

    // Timer register bank
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q    <= 1'b0;
            periodic_q <= 1'b0;
            irq_q      <= 1'b0;
            expr_q     <= '0;
            counter_q  <= '0;
        end else begin
            start_q    <= start_d;
            periodic_q <= periodic_d;
            irq_q      <= irq_d;
            expr_q     <= expr_d;
            counter_q  <= counter_d;
        end
    end

    // Timer update first, then a committing bus write overrides its target
    always_comb begin
        start_d    = start_q;
        periodic_d = periodic_q;
        irq_d      = irq_q;
        expr_d     = expr_q;
        counter_d  = counter_q;
        if (start_q) begin
            if (counter_q == expr_q) begin
                counter_d = '0;
                irq_d     = 1'b1;
                start_d   = periodic_q;
            end else begin
                counter_d = counter_q + 32'd1;
            end
        end
        if (commit) begin
            case (req_idx)
                TIMER_ADDR_CTRL: begin
                    start_d    = req_wdata[TIMER_START_LOC];
                    periodic_d = req_wdata[TIMER_PERIODIC_LOC];
                end
                TIMER_ADDR_INTR:    irq_d     = req_wdata[TIMER_IRQ_LOC];
                TIMER_ADDR_EXPR:    expr_d    = req_wdata;
                TIMER_ADDR_COUNTER: counter_d = req_wdata;
                default: ;
            endcase
        end
    end

    // Read mux; data is driven only during the ready cycle of a read
    always_comb begin
        reg_rd = '0;
        case (req_idx)
            TIMER_ADDR_CTRL: begin
                reg_rd[TIMER_START_LOC]    = start_q;
                reg_rd[TIMER_PERIODIC_LOC] = periodic_q;
            end
            TIMER_ADDR_INTR:    reg_rd[TIMER_IRQ_LOC] = irq_q;
            TIMER_ADDR_EXPR:    reg_rd = expr_q;
            TIMER_ADDR_COUNTER: reg_rd = counter_q;
            default: ;
        endcase
    end

    assign r_data = (ready && req_rw == BUS_READ) ? reg_rd : 32'd0;
    assign rdy_   = ~ready;
    assign irq    = irq_q;

endmodule

// File: tb/tb_yutorina_bus_timer.sv
// Directed bench for yutorina_bus_timer with WAIT_CYCLES=1.
// All stimulus is applied and all outputs sampled 1ns after a rising edge.
module tb_yutorina_bus_timer;

    localparam int ADDR_W = 30;

    logic              clk;
    logic              rst;
    logic              cs_;
    logic              as_;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       w_data;
    logic [31:0]       r_data;
    logic              rdy_;
    logic              irq;

    int checks = 0;
    int errors = 0;

    yutorina_bus_timer #(
        .WAIT_CYCLES (1),
        .ADDR_W      (ADDR_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .cs_    (cs_),
        .as_    (as_),
        .rw     (rw),
        .addr   (addr),
        .w_data (w_data),
        .r_data (r_data),
        .rdy_   (rdy_),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // One full bus access. Called 1ns after an edge; returns 1ns after the
    // edge that ends the ready cycle. lat = cycles from accept edge to the
    // cycle where rdy_ is low (-1 if it never came).
    task automatic bus_access(input logic is_read, input logic [1:0] idx,
                              input logic [31:0] wd, output logic [31:0] rd,
                              output int lat, output logic rdy_after,
                              output logic [31:0] rdata_wait);
        cs_    = 1'b0;
        as_    = 1'b0;
        rw     = is_read;
        addr   = {28'd0, idx};
        w_data = wd;
        lat = -1;
        rd = 32'd0;
        rdata_wait = 32'd0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (rdy_ == 1'b0) begin
                lat = i;
                rd = r_data;
                break;
            end
            if (i == 1) rdata_wait = r_data;
        end
        cs_    = 1'b1;
        as_    = 1'b1;
        rw     = 1'b1;
        w_data = 32'd0;
        @(posedge clk); #1;
        rdy_after = rdy_;
    endtask

    task automatic bus_write(input logic [1:0] idx, input logic [31:0] wd);
        logic [31:0] rd, rw_wait;
        int lat;
        logic ra;
        bus_access(1'b0, idx, wd, rd, lat, ra, rw_wait);
    endtask

    task automatic bus_read(input logic [1:0] idx, output logic [31:0] rd);
        logic [31:0] rw_wait;
        int lat;
        logic ra;
        bus_access(1'b1, idx, 32'd0, rd, lat, ra, rw_wait);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst = 1'b1; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; addr = '0; w_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (rdy_ !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", rdy_); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        checks++; if (r_data !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", r_data); end
        for (int i = 0; i < 4; i++) begin
            bus_read(2'(i), rd);
            checks++;
            if (rd !== 32'd0) begin errors++; $display("FAIL reset_reg%0d: got %h expected 0", i, rd); end
        end
    endtask

    task automatic test_latency();
        logic [31:0] rd, rwait;
        int lat;
        logic ra;
        bus_access(1'b0, 2'd2, 32'd5, rd, lat, ra, rwait);
        checks++; if (lat !== 2) begin errors++; $display("FAIL write_latency: got %0d expected 2", lat); end
        checks++; if (ra !== 1'b1) begin errors++; $display("FAIL write_rdy_single: got %b expected 1", ra); end
        bus_access(1'b1, 2'd2, 32'd0, rd, lat, ra, rwait);
        checks++; if (lat !== 2) begin errors++; $display("FAIL read_latency: got %0d expected 2", lat); end
        checks++; if (rd !== 32'd5) begin errors++; $display("FAIL read_expr: got %h expected 5", rd); end
        checks++; if (rwait !== 32'd0) begin errors++; $display("FAIL rdata_in_wait: got %h expected 0", rwait); end
        checks++; if (ra !== 1'b1) begin errors++; $display("FAIL read_rdy_single: got %b expected 1", ra); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, rwait;
        int lat;
        logic ra;
        bus_access(1'b0, 2'd2, 32'hA5A5_0007, rd, lat, ra, rwait);
        bus_access(1'b1, 2'd2, 32'd0, rd, lat, ra, rwait);
        checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_latency: got %0d expected 2", lat); end
        checks++; if (rd !== 32'hA5A5_0007) begin errors++; $display("FAIL b2b_read: got %h expected a5a50007", rd); end
    endtask

    task automatic test_no_select();
        int low_seen = 0;
        cs_ = 1'b1; as_ = 1'b0; rw = 1'b0; addr = 30'd2; w_data = 32'hDEAD;
        repeat (4) begin @(posedge clk); #1; if (rdy_ !== 1'b1) low_seen++; end
        cs_ = 1'b0; as_ = 1'b1;
        repeat (4) begin @(posedge clk); #1; if (rdy_ !== 1'b1) low_seen++; end
        cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; w_data = 32'd0;
        checks++; if (low_seen !== 0) begin errors++; $display("FAIL no_select_rdy: got %0d low cycles expected 0", low_seen); end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        int lat = -1;
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 30'd3; w_data = 32'h0000_1234;
        @(posedge clk); #1;
        cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; w_data = 32'd0;
        for (int i = 2; i <= 12; i++) begin
            @(posedge clk); #1;
            if (rdy_ == 1'b0) begin lat = i; break; end
        end
        @(posedge clk); #1;
        checks++; if (lat !== 2) begin errors++; $display("FAIL abort_rdy: got %0d expected 2", lat); end
        bus_read(2'd3, rd);
        checks++; if (rd !== 32'h0000_1234) begin errors++; $display("FAIL abort_commit: got %h expected 00001234", rd); end
    endtask

    task automatic test_periodic();
        bus_write(2'd3, 32'd0);
        bus_write(2'd2, 32'd3);
        bus_write(2'd0, 32'd3);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL periodic_start_irq: got %b expected 0", irq); end
        repeat (3) @(posedge clk); #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL periodic_early: got %b expected 0", irq); end
        @(posedge clk); #1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL periodic_first: got %b expected 1", irq); end
        bus_write(2'd1, 32'd0);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL periodic_clear: got %b expected 0", irq); end
        @(posedge clk); #1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL periodic_second: got %b expected 1", irq); end
        bus_write(2'd0, 32'd0);
        bus_write(2'd1, 32'd0);
    endtask

    task automatic test_clear_race();
        bus_write(2'd3, 32'd0);
        bus_write(2'd2, 32'd3);
        bus_write(2'd0, 32'd3);
        @(posedge clk); #1;
        bus_write(2'd1, 32'd0);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL race_irq: got %b expected 0", irq); end
        repeat (3) @(posedge clk); #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL race_restart: got %b expected 0", irq); end
        @(posedge clk); #1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL race_next: got %b expected 1", irq); end
        bus_write(2'd0, 32'd0);
        bus_write(2'd1, 32'd0);
    endtask

    task automatic test_expr_zero();
        bus_write(2'd3, 32'd0);
        bus_write(2'd2, 32'd0);
        bus_write(2'd0, 32'd3);
        @(posedge clk); #1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL expr0_first: got %b expected 1", irq); end
        bus_write(2'd1, 32'd0);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL expr0_clear: got %b expected 0", irq); end
        @(posedge clk); #1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL expr0_again: got %b expected 1", irq); end
        bus_write(2'd0, 32'd0);
        bus_write(2'd1, 32'd0);
        repeat (2) @(posedge clk); #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL expr0_stop: got %b expected 0", irq); end
    endtask

    task automatic test_oneshot();
        logic [31:0] rd;
        bus_write(2'd3, 32'd0);
        bus_write(2'd2, 32'd2);
        bus_write(2'd0, 32'd1);
        repeat (2) @(posedge clk); #1;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_early: got %b expected 0", irq); end
        @(posedge clk); #1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq: got %b expected 1", irq); end
        bus_read(2'd0, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL oneshot_ctrl: got %h expected 0", rd); end
        bus_read(2'd3, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL oneshot_counter: got %h expected 0", rd); end
        bus_read(2'd1, rd);
        checks++; if (rd !== 32'd1) begin errors++; $display("FAIL oneshot_intr: got %h expected 1", rd); end
        bus_write(2'd1, 32'd0);
    endtask

    task automatic test_reset_mid_access();
        logic [31:0] rd;
        int low_seen = 0;
        bus_write(2'd2, 32'd9);
        bus_write(2'd1, 32'hFFFF_FFFF);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL intr_set: got %b expected 1", irq); end
        cs_ = 1'b0; as_ = 1'b0; rw = 1'b0; addr = 30'd0; w_data = 32'd1;
        @(posedge clk); #1;
        rst = 1'b1; cs_ = 1'b1; as_ = 1'b1; rw = 1'b1; w_data = 32'd0;
        if (rdy_ !== 1'b1) low_seen++;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL midrst_irq: got %b expected 0", irq); end
        repeat (4) begin if (rdy_ !== 1'b1) low_seen++; @(posedge clk); #1; end
        checks++; if (low_seen !== 0) begin errors++; $display("FAIL midrst_rdy: got %0d low cycles expected 0", low_seen); end
        bus_read(2'd0, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL midrst_ctrl: got %h expected 0", rd); end
        bus_read(2'd3, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL midrst_counter: got %h expected 0", rd); end
        bus_read(2'd2, rd);
        checks++; if (rd !== 32'd0) begin errors++; $display("FAIL midrst_expr: got %h expected 0", rd); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_no_select();
        test_abort();
        test_periodic();
        test_clear_race();
        test_expr_zero();
        test_oneshot();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
